// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, next-PC selection, IF/ID register and a circular
// return-address stack that supplies RET targets.
module pc_fetch_stage #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      PCSrc,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] branch_target,
  input  logic            call_push,
  input  logic [PC_W-1:0] call_ret_addr,
  input  logic            stall,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_data,
  output logic [PC_W-1:0] ifid_instr,
  output logic [PC_W-1:0] ifid_pc1,
  output logic            ifid_valid,
  output logic            ras_underflow,
  output logic            ras_overflow
);

  localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  ras_top;
  logic [PC_W-1:0]  ras [RAS_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_top;
  logic [CNT_W-1:0] cnt;
  logic             ras_empty;
  logic             ras_full;
  logic             do_pop;
  logic             do_push;

  assign imem_addr = pc;
  assign pc_plus1  = pc + PC_W'(1);
  assign sp_top    = sp - SP_ONE;
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CNT_FULL);
  assign do_pop    = (PCSrc == 2'b11);
  assign do_push   = call_push;
  assign ras_top   = ras_empty ? '0 : ras[sp_top];

  always_comb begin
    next_pc = pc_plus1;
    unique case (PCSrc)
      2'b00: next_pc = pc_plus1;
      2'b01: next_pc = jump_target;
      2'b10: next_pc = branch_target;
      2'b11: next_pc = ras_top;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      ifid_instr <= '0;
      ifid_pc1   <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= next_pc;
      ifid_pc1 <= pc_plus1;
      // any redirect squashes the sequential fetch already in flight
      if (PCSrc == 2'b00) begin
        ifid_instr <= imem_data;
        ifid_valid <= 1'b1;
      end else begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      sp            <= '0;
      cnt           <= '0;
      ras_underflow <= 1'b0;
      ras_overflow  <= 1'b0;
    end else if (!stall) begin
      if (do_pop && do_push) begin
        // return and call in one cycle: the new address replaces the top slot
        ras[sp_top] <= call_ret_addr;
        if (ras_empty) begin
          cnt           <= CNT_ONE;
          ras_underflow <= 1'b1;
        end
      end else if (do_pop) begin
        if (ras_empty) begin
          ras_underflow <= 1'b1;
        end else begin
          sp  <= sp_top;
          cnt <= cnt - CNT_ONE;
        end
      end else if (do_push) begin
        ras[sp] <= call_ret_addr;
        sp      <= sp + SP_ONE;
        if (ras_full) ras_overflow <= 1'b1;
        else          cnt          <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus random stimulus checked
// against a queue-based reference model of the fetch stage and its stack.
module tb_pc_fetch_stage;

  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      pcsrc;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] branch_target;
  logic            call_push;
  logic [PC_W-1:0] call_ret_addr;
  logic            stall;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] imem_data;
  logic [PC_W-1:0] ifid_instr;
  logic [PC_W-1:0] ifid_pc1;
  logic            ifid_valid;
  logic            ras_underflow;
  logic            ras_overflow;

  always #5 clk = ~clk;

  assign imem_data = imem_addr + 16'h1000;

  pc_fetch_stage #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCSrc         (pcsrc),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .call_push     (call_push),
    .call_ret_addr (call_ret_addr),
    .stall         (stall),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc1      (ifid_pc1),
    .ifid_valid    (ifid_valid),
    .ras_underflow (ras_underflow),
    .ras_overflow  (ras_overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_pc, m_instr, m_pc1;
  logic        m_valid, m_uf, m_of;
  logic [15:0] m_stack[$];
  logic [15:0] saved_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = '0; m_pc1 = '0; m_valid = 1'b0;
    m_uf = 1'b0; m_of = 1'b0;
    m_stack.delete();
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".addr"},  imem_addr,     m_pc);
    check_eq({tag, ".instr"}, ifid_instr,    m_instr);
    check_eq({tag, ".pc1"},   ifid_pc1,      m_pc1);
    check_eq({tag, ".valid"}, ifid_valid,    m_valid);
    check_eq({tag, ".uf"},    ras_underflow, m_uf);
    check_eq({tag, ".of"},    ras_overflow,  m_of);
  endtask

  // Starts and ends at a falling edge; one rising edge in between.
  task automatic step(input string tag, input logic st, input logic [1:0] src,
                      input logic [15:0] jt, input logic [15:0] bt,
                      input logic push, input logic [15:0] ra);
    logic [15:0] p1, tgt;
    stall = st; pcsrc = src; jump_target = jt; branch_target = bt;
    call_push = push; call_ret_addr = ra;
    if (!st) begin
      p1  = m_pc + 16'd1;
      tgt = p1;
      case (src)
        2'd1: tgt = jt;
        2'd2: tgt = bt;
        2'd3: begin
          if (m_stack.size() == 0) begin
            tgt  = 16'h0000;
            m_uf = 1'b1;
            if (push) m_stack.push_back(ra);
          end else begin
            tgt = m_stack[m_stack.size()-1];
            if (push) m_stack[m_stack.size()-1] = ra;
            else      void'(m_stack.pop_back());
          end
        end
        default: ;
      endcase
      if (push && src != 2'd3) begin
        m_stack.push_back(ra);
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_of = 1'b1;
        end
      end
      if (src == 2'd0) begin
        m_instr = m_pc + 16'h1000;
        m_valid = 1'b1;
      end else begin
        m_instr = 16'h0000;
        m_valid = 1'b0;
      end
      m_pc1 = p1;
      m_pc  = tgt;
    end
    @(posedge clk);
    #1;
    check_model(tag);
    @(negedge clk);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 2'd0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_model("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall = 1'b0; pcsrc = 2'd0; jump_target = '0;
    branch_target = '0; call_push = 1'b0; call_ret_addr = '0;
    model_reset();
    #12;
    check_model("reset");
    check_eq("reset.valid0", ifid_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // sequential fetch after reset release
    seq("seq1");
    check_eq("seq1.addr1", imem_addr, 16'h0001);
    check_eq("seq1.instr", ifid_instr, 16'h1000);
    check_eq("seq1.valid", ifid_valid, 1'b1);
    seq("seq2");
    check_eq("seq2.instr", ifid_instr, 16'h1001);
    check_eq("seq2.pc1",   ifid_pc1,   16'h0002);
    seq("seq3");
    check_eq("seq3.addr3", imem_addr, 16'h0003);
    seq("seq4");
    seq("seq5");

    // jump at PC = 5
    step("jump", 1'b0, 2'd1, 16'h0040, '0, 1'b0, '0);
    check_eq("jump.addr",   imem_addr,  16'h0040);
    check_eq("jump.bubble", ifid_valid, 1'b0);
    seq("jump.next");
    check_eq("jump.instr", ifid_instr, 16'h1040);
    check_eq("jump.pc1",   ifid_pc1,   16'h0041);

    // push two, pop three
    step("push1", 1'b0, 2'd0, '0, '0, 1'b1, 16'h0011);
    step("push2", 1'b0, 2'd0, '0, '0, 1'b1, 16'h0022);
    step("ret1", 1'b0, 2'd3, '0, '0, 1'b0, '0);
    check_eq("ret1.tgt", imem_addr, 16'h0022);
    step("ret2", 1'b0, 2'd3, '0, '0, 1'b0, '0);
    check_eq("ret2.tgt", imem_addr, 16'h0011);
    check_eq("ret2.uf",  ras_underflow, 1'b0);
    step("ret3", 1'b0, 2'd3, '0, '0, 1'b0, '0);
    check_eq("ret3.tgt", imem_addr, 16'h0000);
    check_eq("ret3.uf",  ras_underflow, 1'b1);

    // overflow: five pushes into a four-deep stack
    do_reset();
    for (int i = 1; i <= 5; i++)
      step("ovf.push", 1'b0, 2'd0, '0, '0, 1'b1, 16'h0100 + 16'(i));
    check_eq("ovf.flag", ras_overflow, 1'b1);
    for (int i = 5; i >= 2; i--) begin
      step("ovf.pop", 1'b0, 2'd3, '0, '0, 1'b0, '0);
      check_eq("ovf.tgt", imem_addr, 16'h0100 + 16'(i));
    end
    check_eq("ovf.nouf", ras_underflow, 1'b0);

    // stall holds a pending branch
    seq("pre_stall");
    saved_pc = m_pc;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 2'd2, '0, 16'h0100, 1'b1, 16'h0BAD);
      check_eq("stall.pc", imem_addr, saved_pc);
    end
    step("stall.rel", 1'b0, 2'd2, '0, 16'h0100, 1'b0, '0);
    check_eq("stall.br", imem_addr, 16'h0100);

    // wrap and asynchronous reset
    step("to_ffff", 1'b0, 2'd1, 16'hFFFF, '0, 1'b0, '0);
    seq("wrap");
    check_eq("wrap.addr", imem_addr, 16'h0000);
    check_eq("wrap.pc1",  ifid_pc1,  16'h0000);
    seq("wrap2");
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("async.pc",    imem_addr,  16'h0000);
    check_eq("async.valid", ifid_valid, 1'b0);
    check_model("async");
    @(negedge clk);
    reset = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step("rand",
             ($urandom_range(0, 4) == 0),
             2'($urandom_range(0, 3)),
             16'($urandom),
             16'($urandom),
             ($urandom_range(0, 2) == 0),
             16'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Fetch stage that sits directly downstream of the branch/jump decision logic.
- Consumes the 2-bit PCSrc selector and the redirect targets, and holds the program counter register.
- Drives the instruction-memory address and the IF/ID pipeline register.
- Keeps an internal return-address stack; a RET redirect (PCSrc = 11) takes its target from the top of this stack.

Parameters:
- PC_W, 16, width of PC, targets and instruction word (word-addressed, 1 instruction per address)
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2)
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- PCSrc  in  2  next-PC select: 00 = PC+1, 01 = jump, 10 = branch, 11 = return
- jump_target  in  PC_W  absolute jump target, used when PCSrc = 01
- branch_target  in  PC_W  branch target, used when PCSrc = 10
- call_push  in  1  push call_ret_addr onto the return-address stack
- call_ret_addr  in  PC_W  return address for a CALL (PC of the call + 1)
- stall  in  1  freeze PC, IF/ID and the stack this cycle
- imem_addr  out  PC_W  instruction-memory read address (= PC register)
- imem_data  in  PC_W  instruction word; combinational read of imem_addr
- ifid_instr  out  PC_W  registered instruction
- ifid_pc1  out  PC_W  registered PC+1 of ifid_instr
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- ras_underflow  out  1  sticky flag: a RET was taken while the stack was empty
- ras_overflow  out  1  sticky flag: a push was made while the stack was full

Behaviour:
- Reset while reset = 0, asynchronous:
  - PC = RESET_PC.
  - ifid_instr = 0, ifid_pc1 = 0, ifid_valid = 0.
  - Stack pointer = 0, stack count = 0, all stack entries = 0.
  - Both sticky flags = 0.
  - Asserting reset mid-operation discards any pending redirect or stall.
- imem_addr = PC at all times; fetch is 0-latency combinational.
- Next-PC selection when stall = 0:
  - 00: PC+1, wrapping modulo 2^PC_W (16'hFFFF -> 16'h0000).
  - 01: jump_target.
  - 10: branch_target.
  - 11: top-of-stack; if the stack is empty, 16'h0000 and ras_underflow is set.
- IF/ID update when stall = 0:
  - If PCSrc = 00: ifid_instr <= imem_data, ifid_pc1 <= PC+1, ifid_valid <= 1.
  - If PCSrc != 00 (redirect): the wrong-path fetch is squashed. ifid_valid <= 0, ifid_instr <= 0, ifid_pc1 <= PC+1.
  - Redirect penalty is exactly 1 bubble.
- Stall = 1:
  - PC, IF/ID, stack and flags hold.
  - PCSrc and call_push are ignored; the upstream logic re-presents them once stall drops.
  - Stall has priority over redirect and push.
- Return-address stack (circular, RAS_DEPTH entries, count 0..RAS_DEPTH):
  - Push (call_push = 1, PCSrc != 11): write at sp, sp <= sp+1 mod RAS_DEPTH, count <= min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry and sets ras_overflow; count stays RAS_DEPTH.
  - Pop (PCSrc = 11, count > 0): target = entry[sp-1], sp <= sp-1, count <= count-1.
  - Pop when empty: sp and count are unchanged, target = 0, ras_underflow is set.
  - Simultaneous pop and push: the target is the old top; call_ret_addr then replaces that same slot. sp and count are unchanged (an empty stack sets underflow and ends with count = 1).
- Sticky flags clear only on reset.
- No combinational path from PCSrc to imem_addr; the PC is registered.

Test Plan:
- Reset release, stall = 0, PCSrc = 00, imem_data = 16'h1000 + addr:
  - imem_addr steps 0, 1, 2, 3.
  - ifid_valid rises 1 cycle after reset release.
  - IF/ID holds (16'h1000, 1), then (16'h1001, 2).
- At PC = 5 apply PCSrc = 01 with jump_target = 16'h0040:
  - Next PC = 16'h0040 and ifid_valid = 0 for 1 cycle.
  - The next IF/ID holds the instruction at 16'h0040 with ifid_pc1 = 16'h0041.
- Push 16'h0011, 16'h0022, then take PCSrc = 11 twice:
  - The return targets are 16'h0022, then 16'h0011.
  - A third RET gives target 0 and sets ras_underflow.
- With RAS_DEPTH = 4, push 5 addresses A1..A5, then pop 4 times:
  - The targets are A5, A4, A3, A2.
  - ras_overflow = 1.
- Assert stall for 3 cycles while PCSrc = 10 and branch_target = 16'h0100:
  - PC and IF/ID are unchanged.
  - On stall release, the branch is taken to 16'h0100.
- Drive PC to 16'hFFFF with PCSrc = 00:
  - Next PC = 16'h0000.
  - Asserting reset low mid-cycle forces PC = 0 and ifid_valid = 0 immediately, without waiting for a clock edge.
